// File: rtl/pe_ctx_seq.sv
// Self-sequencing CGRA processing element: steps through NCTX local contexts for a
// programmed iteration count. Optional `stall` input when PE_CTX_STALL_EN is defined.
module pe_ctx_seq #(
  parameter int unsigned DW     = 32,
  parameter int unsigned NREG   = 4,
  parameter int unsigned NCTX   = 8,
  localparam int unsigned SW     = $clog2(6 + NREG),
  localparam int unsigned RW     = $clog2(NREG),
  localparam int unsigned CW     = $clog2(NCTX),
  localparam int unsigned INST_W = 4 + 2 * SW + 1 + RW + 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DW-1:0]     din_N,
  input  logic [DW-1:0]     din_S,
  input  logic [DW-1:0]     din_W,
  input  logic [DW-1:0]     din_E,
  input  logic [DW-1:0]     din_LSU,
  input  logic              cfg_we,
  input  logic [CW-1:0]     cfg_addr,
  input  logic [INST_W-1:0] cfg_data,
  input  logic              start,
  input  logic [CW-1:0]     last_ctx,
  input  logic [15:0]       iter_cnt,
`ifdef PE_CTX_STALL_EN
  input  logic              stall,
`endif
  output logic              busy,
  output logic              done,
  output logic [DW-1:0]     dout_N,
  output logic [DW-1:0]     dout_S,
  output logic [DW-1:0]     dout_W,
  output logic [DW-1:0]     dout_E,
  output logic [DW-1:0]     dout_LSU
);

  localparam int unsigned NSRC = 6 + NREG;
  localparam int unsigned SHW  = $clog2(DW);
  localparam logic [CW-1:0] LastMax = CW'(NCTX - 1);
  localparam logic [SW:0]   NSrcW   = (SW + 1)'(NSRC);
  localparam logic [RW:0]   NRegW   = (RW + 1)'(NREG);

  typedef enum logic {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     pc_q, pc_d;
  logic [CW-1:0]     last_q, last_d;
  logic [15:0]       iter_q, iter_d;
  logic              done_q, done_d;
  logic [DW-1:0]     res_q;
  logic [DW-1:0]     rf_q   [NREG];
  logic [DW-1:0]     dout_q [5];
  logic [INST_W-1:0] ctx_mem [NCTX];

  logic              stall_w;
  logic              exec;
  logic [INST_W-1:0] inst;
  logic [3:0]        op;
  logic [SW-1:0]     sel_a, sel_b;
  logic              wen;
  logic [RW-1:0]     wreg;
  logic [4:0]        omask;
  logic [DW-1:0]     src [NSRC];
  logic [DW-1:0]     opnd_a, opnd_b, fu;

`ifdef PE_CTX_STALL_EN
  assign stall_w = stall;
`else
  assign stall_w = 1'b0;
`endif

  assign exec = (state_q == StRun) && !stall_w;
  assign busy = (state_q == StRun);
  assign done = done_q;

  assign dout_N   = dout_q[0];
  assign dout_S   = dout_q[1];
  assign dout_W   = dout_q[2];
  assign dout_E   = dout_q[3];
  assign dout_LSU = dout_q[4];

  // Context word, MSB first: op, srcA, srcB, wen, wreg, omask.
  assign inst  = ctx_mem[pc_q];
  assign op    = inst[INST_W-1 -: 4];
  assign sel_a = inst[INST_W-5 -: SW];
  assign sel_b = inst[INST_W-5-SW -: SW];
  assign wen   = inst[5+RW];
  assign wreg  = inst[5 +: RW];
  assign omask = inst[4:0];

  always_comb begin
    src[0] = din_N;
    src[1] = din_S;
    src[2] = din_W;
    src[3] = din_E;
    src[4] = din_LSU;
    src[5] = res_q;
    for (int k = 0; k < NREG; k++) begin
      src[6+k] = rf_q[k];
    end
  end

  // Unused select codes read as zero.
  assign opnd_a = ({1'b0, sel_a} < NSrcW) ? src[sel_a] : '0;
  assign opnd_b = ({1'b0, sel_b} < NSrcW) ? src[sel_b] : '0;

  always_comb begin
    fu = '0;
    case (op)
      4'd0:    fu = opnd_a + opnd_b;
      4'd1:    fu = opnd_a - opnd_b;
      4'd2:    fu = opnd_a * opnd_b;
      4'd3:    fu = opnd_a & opnd_b;
      4'd4:    fu = opnd_a | opnd_b;
      4'd5:    fu = opnd_a ^ opnd_b;
      4'd6:    fu = opnd_a << opnd_b[SHW-1:0];
      4'd7:    fu = opnd_a >> opnd_b[SHW-1:0];
      4'd8:    fu = opnd_a;
      default: fu = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    last_d  = last_q;
    iter_d  = iter_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          pc_d    = '0;
          last_d  = (last_ctx > LastMax) ? LastMax : last_ctx;
          iter_d  = (iter_cnt == 16'd0) ? 16'd1 : iter_cnt;
          state_d = StRun;
        end
      end
      StRun: begin
        if (exec) begin
          if (pc_q == last_q) begin
            pc_d   = '0;
            iter_d = iter_q - 16'd1;
            if (iter_q == 16'd1) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end
          end else begin
            pc_d = pc_q + CW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= '0;
      last_q  <= '0;
      iter_q  <= '0;
      done_q  <= 1'b0;
      res_q   <= '0;
      for (int k = 0; k < NREG; k++) rf_q[k] <= '0;
      for (int o = 0; o < 5; o++) dout_q[o] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      last_q  <= last_d;
      iter_q  <= iter_d;
      done_q  <= done_d;
      if (exec) begin
        res_q <= fu;
        if (wen && ({1'b0, wreg} < NRegW)) rf_q[wreg] <= fu;
        for (int o = 0; o < 5; o++) begin
          if (omask[o]) dout_q[o] <= fu;
        end
      end
    end
  end

  // Context memory is not reset; writes are only accepted while idle.
  always_ff @(posedge clk) begin
    if (cfg_we && (state_q == StIdle) && (cfg_addr <= LastMax)) begin
      ctx_mem[cfg_addr] <= cfg_data;
    end
  end

endmodule

// File: tb/tb_pe_ctx_seq.sv
// Scoreboard bench for pe_ctx_seq: a behavioural model predicts the dout/done trace of
// each run; a monitor pops one prediction per executed cycle.
module tb_pe_ctx_seq;
  localparam int DW = 32, NREG = 4, NCTX = 6, CW = 3, IW = 20;

  typedef struct packed {
    logic [4:0][DW-1:0] d;
    logic               last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] din  [5];
  logic [DW-1:0] dout [5];
  logic          cfg_we;
  logic [CW-1:0] cfg_addr;
  logic [IW-1:0] cfg_data;
  logic          start;
  logic [CW-1:0] last_ctx;
  logic [15:0]   iter_cnt;
  logic          busy, done;
`ifdef PE_CTX_STALL_EN
  logic          stall = 1'b0;
`endif

  int n_chk = 0, n_pass = 0;
  exp_t exp_q[$];
  logic [IW-1:0] ctx_m [NCTX];
  logic [DW-1:0] din_m [5];
  logic [DW-1:0] reg_m [NREG];
  logic [DW-1:0] dout_m [5];
  logic [DW-1:0] res_m;
  bit prev_busy = 1'b0;

  pe_ctx_seq #(.DW(DW), .NREG(NREG), .NCTX(NCTX)) dut (
    .clk(clk), .rst(rst),
    .din_N(din[0]), .din_S(din[1]), .din_W(din[2]), .din_E(din[3]), .din_LSU(din[4]),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start), .last_ctx(last_ctx), .iter_cnt(iter_cnt),
`ifdef PE_CTX_STALL_EN
    .stall(stall),
`endif
    .busy(busy), .done(done),
    .dout_N(dout[0]), .dout_S(dout[1]), .dout_W(dout[2]), .dout_E(dout[3]),
    .dout_LSU(dout[4])
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  function automatic logic [159:0] dvec();
    return {dout[4], dout[3], dout[2], dout[1], dout[0]};
  endfunction

  function automatic logic [IW-1:0] mk(input int op, input int sa, input int sb,
                                       input int wen, input int wreg, input int om);
    return {4'(op), 4'(sa), 4'(sb), 1'(wen), 2'(wreg), 5'(om)};
  endfunction

  function automatic logic [DW-1:0] alu(input int op, input logic [DW-1:0] a,
                                        input logic [DW-1:0] b);
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a * b;
      3: return a & b;
      4: return a | b;
      5: return a ^ b;
      6: return a << (b % DW);
      7: return a >> (b % DW);
      8: return a;
      default: return '0;
    endcase
  endfunction

  function automatic logic [DW-1:0] src_val(input int sel);
    if (sel < 5) return din_m[sel];
    if (sel == 5) return res_m;
    if (sel < 6 + NREG) return reg_m[sel-6];
    return '0;
  endfunction

  task automatic model_zero();
    res_m = '0;
    for (int k = 0; k < NREG; k++) reg_m[k] = '0;
    for (int o = 0; o < 5; o++) dout_m[o] = '0;
  endtask

  // Walk the whole run: iters passes over contexts 0..last, one prediction per context.
  task automatic model_run(input int last, input int iters);
    exp_t e;
    logic [IW-1:0] w;
    logic [DW-1:0] a, b, r;
    for (int it = 0; it < iters; it++) begin
      for (int p = 0; p <= last; p++) begin
        w = ctx_m[p];
        a = src_val(int'(w[15:12]));
        b = src_val(int'(w[11:8]));
        r = alu(int'(w[19:16]), a, b);
        res_m = r;
        if (w[7]) reg_m[w[6:5]] = r;
        for (int o = 0; o < 5; o++) if (w[o]) dout_m[o] = r;
        for (int o = 0; o < 5; o++) e.d[o] = dout_m[o];
        e.last = (it == iters - 1) && (p == last);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic cfg_write(input int addr, input logic [IW-1:0] w);
    @(negedge clk); #1;
    cfg_we = 1'b1; cfg_addr = CW'(addr); cfg_data = w;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    if (addr < NCTX) ctx_m[addr] = w;
  endtask

  task automatic program_random();
    for (int i = 0; i < NCTX; i++) cfg_write(i, IW'($urandom));
  endtask

  task automatic rand_din();
    for (int o = 0; o < 5; o++) din[o] = $urandom;
  endtask

  task automatic start_run(input int last_in, input int iter_in, input bit chain,
                           input bit cfg_same, input logic [IW-1:0] same_word,
                           input bit cfg_mid, input logic [IW-1:0] mid_word);
    int cl, it;
    cl = (last_in > NCTX - 1) ? NCTX - 1 : last_in;
    it = (iter_in == 0) ? 1 : iter_in;
    if (!chain) begin
      @(negedge clk); #1;
    end
    last_ctx = CW'(last_in); iter_cnt = 16'(iter_in); start = 1'b1;
    if (cfg_same) begin
      cfg_we = 1'b1; cfg_addr = '0; cfg_data = same_word; ctx_m[0] = same_word;
    end
    for (int o = 0; o < 5; o++) din_m[o] = din[o];
    model_run(cl, it);
    @(posedge clk); #1;
    start = 1'b0; cfg_we = 1'b0;
    if (cfg_mid) begin
      cfg_we = 1'b1; cfg_addr = '0; cfg_data = mid_word;
      @(posedge clk); #1;
      cfg_we = 1'b0;
    end
  endtask

  task automatic wait_run(input int last_in, input int iter_in);
    int budget, n;
    budget = (((last_in > NCTX - 1) ? NCTX : last_in + 1) * ((iter_in == 0) ? 1 : iter_in)) + 6;
    n = 0;
    do begin
      @(negedge clk); #2;
      n++;
    end while ((busy || exp_q.size() != 0) && n < budget);
    check("run_end", {busy, exp_q.size() != 0}, '0);
  endtask

  task automatic run(input int last_in, input int iter_in);
    start_run(last_in, iter_in, 1'b0, 1'b0, '0, 1'b0, '0);
    wait_run(last_in, iter_in);
  endtask

  task automatic reset_idle();
    @(negedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    model_zero();
    @(negedge clk); #1;
    rst = 1'b0;
  endtask

  // Monitor: each cycle after an executing cycle must match the next prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_busy = 1'b0;
      end else begin
        if (prev_busy) begin
          if (exp_q.size() == 0) begin
            check("unexpected_exec", 160'(busy), 160'(0));
          end else begin
            e = exp_q.pop_front();
            check("dout", dvec(), e.d);
            check("done", 160'(done), 160'(e.last));
            check("busy", 160'(busy), 160'(!e.last));
          end
        end else begin
          check("done_idle", 160'(done), 160'(0));
        end
        prev_busy = busy;
      end
    end
  end

  initial begin
    int last_r, iter_r;
    bit chain, same, mid;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    start = 1'b0; last_ctx = '0; iter_cnt = '0;
    for (int o = 0; o < 5; o++) din[o] = '0;
    model_zero();

    repeat (2) @(negedge clk);
    check("rst_dout", dvec(), '0);
    check("rst_busy_done", {busy, done}, '0);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_dout", dvec(), '0);

    // Single context: ADD(N,S) -> E.
    cfg_write(0, mk(0, 0, 1, 0, 0, 5'b01000));
    rand_din(); din[0] = 3; din[1] = 4;
    run(0, 1);
    check("single_E", 160'(dout[3]), 160'(7));
    check("single_others", {dout[0], dout[1], dout[2], dout[4]}, '0);

    // Accumulate res + W into LSU four times.
    reset_idle();
    cfg_write(0, mk(0, 5, 2, 0, 0, 5'b10000));
    rand_din(); din[2] = 5;
    run(0, 4);
    check("accum_LSU", 160'(dout[4]), 160'(20));

    // Register chaining through R1.
    cfg_write(0, mk(8, 0, 0, 1, 1, 0));
    cfg_write(1, mk(2, 7, 0, 0, 0, 5'b00010));
    rand_din(); din[0] = 6;
    run(1, 1);
    check("chain_S", 160'(dout[1]), 160'(36));

    // SHL by 33 shifts by 1; iter_cnt 0 acts as 1.
    cfg_write(0, mk(6, 0, 1, 0, 0, 5'b00001));
    rand_din(); din[0] = 3; din[1] = 33;
    run(0, 0);
    check("shl33_N", 160'(dout[0]), 160'(6));

    // Op 12 yields zero on all outputs.
    cfg_write(0, mk(12, 0, 1, 0, 0, 5'h1f));
    rand_din();
    run(0, 1);
    check("op12_zero", dvec(), '0);

    // cfg_we during RUN is ignored.
    cfg_write(0, mk(0, 0, 1, 0, 0, 5'h1f));
    rand_din();
    start_run(0, 2, 1'b0, 1'b0, '0, 1'b1, mk(5, 0, 0, 0, 0, 5'h1f));
    wait_run(0, 2);
    rand_din();
    run(0, 1);
    check("cfg_run_ignored", 160'(dout[2]), 160'(din[0] + din[1]));

    // cfg write on the start edge is seen by the first fetch.
    rand_din();
    start_run(0, 1, 1'b0, 1'b1, mk(1, 0, 1, 0, 0, 5'h1f), 1'b0, '0);
    wait_run(0, 1);
    check("cfg_with_start", 160'(dout[3]), 160'(din[0] - din[1]));

    // last_ctx beyond NCTX-1 clamps; then a start in the done cycle.
    program_random();
    rand_din();
    run(7, 2);
    rand_din();
    start_run(3, 1, 1'b1, 1'b0, '0, 1'b0, '0);
    wait_run(3, 1);

    for (int i = 0; i < 20; i++) begin
      chain  = ($urandom_range(0, 2) == 0);
      same   = ($urandom_range(0, 3) == 0);
      mid    = ($urandom_range(0, 3) == 0);
      last_r = $urandom_range(0, 7);
      iter_r = $urandom_range(0, 3);
      if (!chain) program_random();
      rand_din();
      start_run(last_r, iter_r, chain, same, IW'($urandom), mid, IW'($urandom));
      wait_run(last_r, iter_r);
    end

    // Reset in the middle of a run aborts with no done pulse.
    program_random();
    rand_din();
    start_run(5, 4, 1'b0, 1'b0, '0, 1'b0, '0);
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_dout", dvec(), '0);
    check("midrst_busy_done", {busy, done}, '0);
    exp_q.delete();
    model_zero();
    @(negedge clk); #1;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("midrst_idle", {busy, done}, '0);
    check("midrst_hold", dvec(), '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
